// File: rtl/uart_rx_os_if.sv
// ----------------------------------------------------------------------------
// uart_rx_os_if
// Purpose : AXI4-Stream style bundle carrying received UART words from the
//           receiver (master) to the peripheral/CPU interconnect (slave).
// Signals : tdata  - received data word, DWIDTH bits
//           tuser  - {parity_err, frame_err} belonging to tdata
//           tvalid - word available
//           tready - sink accepts the word this cycle
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface uart_rx_os_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] tdata;
  logic [1:0]        tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_os.sv
// ----------------------------------------------------------------------------
// uart_rx_os
// Purpose : Oversampling UART receiver. The serial line is resynchronised,
//           start bits are validated at mid-bit, data/parity/stop bits are
//           sampled at bit centres on an external baud*OSR tick, and each
//           completed frame is pushed with its error flags into a small
//           receive buffer that drives an AXI4-Stream master.
// Ports   : uart_clk        - clock
//           uart_rst_n      - asynchronous active-low reset
//           uart_tick       - one-cycle pulse at baud*OSR; the FSM only moves on it
//           uart_rxd        - serial input, idles high
//           m_axis          - stream master (tdata, tuser={par,frame}, tvalid, tready)
//           uart_busy       - frame in progress
//           uart_parity_err - 1-cycle pulse, parity mismatch on the pushed word
//           uart_frame_err  - 1-cycle pulse, a stop bit was sampled low
//           uart_overrun    - 1-cycle pulse, word dropped because buffer full
// Config  : UART_RX_FIFO_EN defined   -> FIFO_DEPTH-entry order-preserving FIFO
//           UART_RX_FIFO_EN undefined -> single output register
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int         DWIDTH     = 8,
  parameter int         OSR        = 16,
  parameter logic [1:0] PARTYP     = 2'b00,
  parameter int         STOPB      = 1,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic         uart_clk,
  input  logic         uart_rst_n,
  input  logic         uart_tick,
  input  logic         uart_rxd,
  uart_rx_os_if.master m_axis,
  output logic         uart_busy,
  output logic         uart_parity_err,
  output logic         uart_frame_err,
  output logic         uart_overrun
);

  localparam int SCW = $clog2(OSR);
  localparam int BCW = $clog2(DWIDTH + 1);
  localparam int WW  = DWIDTH + 2;

  localparam logic [SCW-1:0] HALF_LAST = SCW'(OSR / 2 - 1);
  localparam logic [SCW-1:0] FULL_LAST = SCW'(OSR - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DWIDTH - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOPB - 1);
  localparam bit             HAS_PAR   = (PARTYP == 2'b01) || (PARTYP == 2'b10);

  // Elaboration-time guard against parameter sets the datapath cannot handle.
  if ((DWIDTH < 5) || (DWIDTH > 9) || (OSR < 4) || ((OSR % 2) != 0) ||
      (STOPB < 1) || (STOPB > 2) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
    $error("uart_rx_os: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [SCW-1:0]    sampleCnt_q, sampleCnt_d;
  logic [BCW-1:0]    bitCnt_q, bitCnt_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              parErr_q, parErr_d;
  logic              frameErr_q, frameErr_d;
  logic              armed_q, armed_d;
  logic              rxdMeta_q, rxdSync_q;

  logic              push;
  logic              pushParErr;
  logic              pushFrameErr;
  logic              sampleLast;
  logic              stopErr;
  logic [WW-1:0]     pushWord;

  logic              bufValid;
  logic              pop;
  logic              pushOk;
  logic [WW-1:0]     bufWord;

  // Two-flop synchroniser for the asynchronous serial line. It resets to the
  // idle level so a reset never looks like a start bit.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      rxdMeta_q <= 1'b1;
      rxdSync_q <= 1'b1;
    end else begin
      rxdMeta_q <= uart_rxd;
      rxdSync_q <= rxdMeta_q;
    end
  end

  // Receiver state register. Everything here only changes when the next-state
  // logic says so, and that logic holds still between ticks.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q     <= ST_IDLE;
      sampleCnt_q <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parErr_q    <= 1'b0;
      frameErr_q  <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parErr_q    <= parErr_d;
      frameErr_q  <= frameErr_d;
      armed_q     <= armed_d;
    end
  end

  // Next-state logic. The start bit is checked half a bit in; from then on the
  // sample counter wraps every OSR ticks so each later sample lands on a bit
  // centre. A frame error disarms the receiver until the line is seen high
  // again, so a held break does not produce a stream of zero words. The push
  // happens on the tick of the last stop sample.
  always_comb begin
    state_d      = state_q;
    sampleCnt_d  = sampleCnt_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    parErr_d     = parErr_q;
    frameErr_d   = frameErr_q;
    armed_d      = armed_q;
    push         = 1'b0;
    pushParErr   = 1'b0;
    pushFrameErr = 1'b0;
    sampleLast   = (sampleCnt_q == FULL_LAST);
    stopErr      = frameErr_q | ~rxdSync_q;

    if (rxdSync_q) begin
      armed_d = 1'b1;
    end

    if (uart_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxdSync_q && armed_q) begin
            sampleCnt_d = '0;
            bitCnt_d    = '0;
            parErr_d    = 1'b0;
            frameErr_d  = 1'b0;
            state_d     = ST_START;
          end
        end
        ST_START: begin
          if (sampleCnt_q == HALF_LAST) begin
            if (rxdSync_q) begin
              state_d = ST_IDLE;
            end else begin
              sampleCnt_d = '0;
              state_d     = ST_DATA;
            end
          end else begin
            sampleCnt_d = sampleCnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (sampleLast) begin
            sampleCnt_d = '0;
            shift_d     = {rxdSync_q, shift_q[DWIDTH-1:1]};
            if (bitCnt_q == DATA_LAST) begin
              bitCnt_d = '0;
              state_d  = HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bitCnt_d = bitCnt_q + 1'b1;
            end
          end else begin
            sampleCnt_d = sampleCnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (sampleLast) begin
            sampleCnt_d = '0;
            parErr_d    = (PARTYP == 2'b01) ? ~(^{shift_q, rxdSync_q})
                                            :  (^{shift_q, rxdSync_q});
            state_d     = ST_STOP;
          end else begin
            sampleCnt_d = sampleCnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (sampleLast) begin
            sampleCnt_d = '0;
            frameErr_d  = stopErr;
            if (bitCnt_q == STOP_LAST) begin
              push         = 1'b1;
              pushParErr   = parErr_q;
              pushFrameErr = stopErr;
              state_d      = ST_IDLE;
              if (stopErr) begin
                armed_d = 1'b0;
              end
            end else begin
              bitCnt_d = bitCnt_q + 1'b1;
            end
          end else begin
            sampleCnt_d = sampleCnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign pushWord = {pushParErr, pushFrameErr, shift_q};

`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW-1:0] wrPtrNext, rdPtrNext;
  logic          full_q;
  logic          empty;

  assign wrPtrNext    = wrPtr_q + 1'b1;
  assign rdPtrNext    = rdPtr_q + 1'b1;
  assign empty        = (wrPtr_q == rdPtr_q) && !full_q;
  assign bufValid     = !empty;
  assign pop          = bufValid && m_axis.tready;
  assign pushOk       = push && (!full_q || pop);
  assign uart_overrun = push && full_q && !pop;
  assign bufWord      = mem_q[rdPtr_q];

  // FIFO pointers wrap naturally because the depth is a power of two; the
  // separate full flag tells "full" apart from "empty" when they meet. A push
  // and pop in the same cycle leaves the fill level, and so the flag, as is.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= wrPtrNext;
      end
      if (pop) begin
        rdPtr_q <= rdPtrNext;
      end
      if (pushOk && !pop) begin
        full_q <= (wrPtrNext == rdPtr_q);
      end else if (pop && !pushOk) begin
        full_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the output is masked while the FIFO is empty.
  always_ff @(posedge uart_clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= pushWord;
    end
  end
`else
  logic [WW-1:0] hold_q;
  logic          valid_q;

  assign bufValid     = valid_q;
  assign pop          = valid_q && m_axis.tready;
  assign pushOk       = push && (!valid_q || pop);
  assign uart_overrun = push && valid_q && !m_axis.tready;
  assign bufWord      = hold_q;

  // Single output register. A new word may replace one that is leaving in the
  // same cycle; otherwise an occupied register keeps its word and the new one
  // is dropped.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (pushOk) begin
        hold_q  <= pushWord;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end
`endif

  assign m_axis.tvalid   = bufValid;
  assign m_axis.tdata    = bufValid ? bufWord[DWIDTH-1:0] : '0;
  assign m_axis.tuser    = bufValid ? bufWord[WW-1:DWIDTH] : 2'b00;
  assign uart_busy       = (state_q != ST_IDLE);
  assign uart_parity_err = pushParErr;
  assign uart_frame_err  = pushFrameErr;

endmodule

// File: tb/tb_uart_rx_os.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_os
// Directed bench for uart_rx_os. Two receivers are instantiated: dutA is 8N1
// and dutB is 8 data bits, odd parity, two stop bits. Both see a tick every
// four clocks, so one bit on the wire lasts 16 ticks = 64 clocks.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int BITCLK = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic rxdA, rxdB;
  logic busyA, parA, frameA, ovrA;
  logic busyB, parB, frameB, ovrB;
  int   tickCnt = 0;

  int   testsRun  = 0;
  int   failCount = 0;

  logic [9:0] beatsA[$];
  logic [9:0] beatsB[$];
  int   parCntA, frameCntA, ovrCntA, busyCycA;
  int   parCntB, frameCntB, ovrCntB;

  uart_rx_os_if #(.DWIDTH(8)) axA ();
  uart_rx_os_if #(.DWIDTH(8)) axB ();

  uart_rx_os dutA (
    .uart_clk        (clk),
    .uart_rst_n      (rst_n),
    .uart_tick       (tick),
    .uart_rxd        (rxdA),
    .m_axis          (axA),
    .uart_busy       (busyA),
    .uart_parity_err (parA),
    .uart_frame_err  (frameA),
    .uart_overrun    (ovrA)
  );

  uart_rx_os #(.PARTYP(2'b01), .STOPB(2)) dutB (
    .uart_clk        (clk),
    .uart_rst_n      (rst_n),
    .uart_tick       (tick),
    .uart_rxd        (rxdB),
    .m_axis          (axB),
    .uart_busy       (busyB),
    .uart_parity_err (parB),
    .uart_frame_err  (frameB),
    .uart_overrun    (ovrB)
  );

  always #5 clk = ~clk;

  // Free-running oversample tick, one clock high out of every four.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick    = (tickCnt == 3);
      tickCnt = (tickCnt == 3) ? 0 : tickCnt + 1;
    end
  end

  // Observe the stream handshakes and pulse outputs half a clock away from
  // the active edge, where everything for the coming edge is settled.
  always @(negedge clk) begin
    if (axA.tvalid && axA.tready) beatsA.push_back({axA.tuser, axA.tdata});
    if (axB.tvalid && axB.tready) beatsB.push_back({axB.tuser, axB.tdata});
    if (parA)   parCntA++;
    if (frameA) frameCntA++;
    if (ovrA)   ovrCntA++;
    if (busyA)  busyCycA++;
    if (parB)   parCntB++;
    if (frameB) frameCntB++;
    if (ovrB)   ovrCntB++;
  end

  // Hard stop in case a wait never ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearMon();
    beatsA.delete();
    beatsB.delete();
    parCntA = 0; frameCntA = 0; ovrCntA = 0; busyCycA = 0;
    parCntB = 0; frameCntB = 0; ovrCntB = 0;
  endtask

  // Shift n bits of a prepared frame onto one line, LSB first, one bit time each.
  task automatic applyStimulus(input bit selB, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (selB) rxdB = bits[i];
      else      rxdA = bits[i];
      step(BITCLK);
    end
  endtask

  task automatic sendA(input logic [7:0] data, input logic stopBit);
    applyStimulus(1'b0, {6'b0, stopBit, data, 1'b0}, 10);
    rxdA = 1'b1;
    step(BITCLK);
  endtask

  task automatic sendB(input logic [7:0] data, input logic p);
    applyStimulus(1'b1, {4'b0, 1'b1, 1'b1, p, data, 1'b0}, 12);
    rxdB = 1'b1;
    step(BITCLK);
  endtask

  task automatic takeBeat(input bit selB, output logic [9:0] w);
    w = 10'h3FF;
    if (selB) begin
      if (beatsB.size() > 0) w = beatsB.pop_front();
    end else begin
      if (beatsA.size() > 0) w = beatsA.pop_front();
    end
  endtask

  initial begin
    logic [9:0] w;

    rst_n      = 1'b0;
    rxdA       = 1'b1;
    rxdB       = 1'b1;
    axA.tready = 1'b0;
    axB.tready = 1'b0;
    clearMon();
    step(3);

    // Reset state.
    checkOutput("rst A tvalid", 32'(axA.tvalid), 32'h0);
    checkOutput("rst A tdata",  32'(axA.tdata),  32'h0);
    checkOutput("rst A tuser",  32'(axA.tuser),  32'h0);
    checkOutput("rst A busy",   32'(busyA),      32'h0);
    checkOutput("rst A pulses", 32'({parA, frameA, ovrA}), 32'h0);
    checkOutput("rst B tvalid", 32'(axB.tvalid), 32'h0);
    checkOutput("rst B busy",   32'(busyB),      32'h0);
    rst_n = 1'b1;
    step(BITCLK);

    // 8N1 frame 0xA5 with the sink always ready.
    axA.tready = 1'b1;
    clearMon();
    sendA(8'hA5, 1'b1);
    checkOutput("t1 beats", 32'(beatsA.size()), 32'd1);
    takeBeat(1'b0, w);
    checkOutput("t1 word", 32'(w), 32'h0A5);
    checkOutput("t1 busy cycles", 32'(busyCycA), 32'd608);
    checkOutput("t1 pulses", 32'(parCntA + frameCntA + ovrCntA), 32'd0);
    checkOutput("t1 busy idle", 32'(busyA), 32'h0);
    checkOutput("t1 tvalid idle", 32'(axA.tvalid), 32'h0);
    checkOutput("t1 tdata idle", 32'(axA.tdata), 32'h0);

    // Odd parity: 0x03 needs p=1; p=0 is flagged.
    axB.tready = 1'b1;
    clearMon();
    sendB(8'h03, 1'b0);
    checkOutput("t2 bad beats", 32'(beatsB.size()), 32'd1);
    takeBeat(1'b1, w);
    checkOutput("t2 bad word", 32'(w), 32'h203);
    checkOutput("t2 bad parpulse", 32'(parCntB), 32'd1);
    checkOutput("t2 bad framepulse", 32'(frameCntB), 32'd0);
    clearMon();
    sendB(8'h03, 1'b1);
    checkOutput("t2 good beats", 32'(beatsB.size()), 32'd1);
    takeBeat(1'b1, w);
    checkOutput("t2 good word", 32'(w), 32'h003);
    checkOutput("t2 good parpulse", 32'(parCntB), 32'd0);
    clearMon();
    sendB(8'hF0, 1'b1);
    takeBeat(1'b1, w);
    checkOutput("t2 F0 word", 32'(w), 32'h0F0);

    // Glitch on the line shorter than half a bit.
    clearMon();
    rxdA = 1'b0;
    step(16);
    checkOutput("t3 busy during", 32'(busyA), 32'h1);
    rxdA = 1'b1;
    step(2 * BITCLK);
    checkOutput("t3 beats", 32'(beatsA.size()), 32'd0);
    checkOutput("t3 busy cycles", 32'(busyCycA), 32'd32);
    checkOutput("t3 pulses", 32'(parCntA + frameCntA + ovrCntA), 32'd0);
    checkOutput("t3 busy after", 32'(busyA), 32'h0);

    // Stop bit low followed by a held break.
    clearMon();
    applyStimulus(1'b0, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
    step(3 * BITCLK);
    checkOutput("t4 busy in break", 32'(busyA), 32'h0);
    checkOutput("t4 beats", 32'(beatsA.size()), 32'd1);
    takeBeat(1'b0, w);
    checkOutput("t4 word", 32'(w), 32'h155);
    checkOutput("t4 framepulse", 32'(frameCntA), 32'd1);
    checkOutput("t4 busy cycles", 32'(busyCycA), 32'd608);
    rxdA = 1'b1;
    step(2 * BITCLK);
    checkOutput("t4 no retrigger", 32'(beatsA.size()), 32'd0);
    clearMon();
    sendA(8'h96, 1'b1);
    takeBeat(1'b0, w);
    checkOutput("t4 rearmed word", 32'(w), 32'h096);

    // Buffer full behaviour with the sink stalled.
    axA.tready = 1'b0;
    clearMon();
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 4; i++) begin
      sendA(8'(i), 1'b1);
    end
    checkOutput("t5 no overrun yet", 32'(ovrCntA), 32'd0);
    sendA(8'h05, 1'b1);
    checkOutput("t5 overrun", 32'(ovrCntA), 32'd1);
    checkOutput("t5 head tdata", 32'(axA.tdata), 32'h01);
    checkOutput("t5 beats stalled", 32'(beatsA.size()), 32'd0);
    axA.tready = 1'b1;
    step(10);
    checkOutput("t5 drained", 32'(beatsA.size()), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      takeBeat(1'b0, w);
      checkOutput("t5 drain word", 32'(w), 32'(i));
    end
`else
    sendA(8'h11, 1'b1);
    checkOutput("t5 held tvalid", 32'(axA.tvalid), 32'h1);
    checkOutput("t5 held tdata", 32'(axA.tdata), 32'h11);
    checkOutput("t5 no overrun yet", 32'(ovrCntA), 32'd0);
    sendA(8'h22, 1'b1);
    checkOutput("t5 overrun", 32'(ovrCntA), 32'd1);
    checkOutput("t5 kept tdata", 32'(axA.tdata), 32'h11);
    axA.tready = 1'b1;
    step(1);
    axA.tready = 1'b0;
    step(2);
    checkOutput("t5 drained", 32'(beatsA.size()), 32'd1);
    takeBeat(1'b0, w);
    checkOutput("t5 drain word", 32'(w), 32'h011);
`endif
    checkOutput("t5 tvalid empty", 32'(axA.tvalid), 32'h0);
    checkOutput("t5 tdata empty", 32'(axA.tdata), 32'h0);

    // Reset in the middle of a frame, with a word waiting in the buffer.
    axA.tready = 1'b0;
    clearMon();
    sendA(8'h5A, 1'b1);
    checkOutput("t6 preload tvalid", 32'(axA.tvalid), 32'h1);
    applyStimulus(1'b0, 16'h0010, 4);
    step(BITCLK / 2);
    checkOutput("t6 busy mid", 32'(busyA), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6 rst tvalid", 32'(axA.tvalid), 32'h0);
    checkOutput("t6 rst busy", 32'(busyA), 32'h0);
    checkOutput("t6 rst tdata", 32'(axA.tdata), 32'h0);
    rxdA = 1'b1;
    step(4);
    rst_n = 1'b1;
    step(BITCLK);
    axA.tready = 1'b1;
    clearMon();
    sendA(8'hC3, 1'b1);
    checkOutput("t6 beats", 32'(beatsA.size()), 32'd1);
    takeBeat(1'b0, w);
    checkOutput("t6 word", 32'(w), 32'h0C3);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
